fft_frame_arbiter: RTL

- Shares the single FFT + 4-window averaging output path between two sample-stream requesters (ch0, ch1).
- Grants whole averaging groups: NUM_WIN consecutive frames of FRAME_LEN samples from one channel.
- Holds off the next grant until the averaged result of the current group has fully drained.
- Tags the drained result with its source channel; sits between the input capture logic and the FFT core input.

---
 rtl/fft_ctrl_pkg.sv | 24 ++
 rtl/fft_frame_arbiter_rr_pick2.sv | 21 ++
 rtl/fft_frame_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared control definitions for the FFT input arbiter: arbiter state
// encoding, default frame geometry and the channel identifier type.
package fft_ctrl_pkg;

    localparam int unsigned FFT_FRAME_LEN = 128;
    localparam int unsigned FFT_NUM_WIN   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_STREAM = 2'd1,
        ARB_DRAIN  = 2'd2
    } arb_state_e;

    typedef logic chan_id_t;

    localparam chan_id_t CH0 = 1'b0;
    localparam chan_id_t CH1 = 1'b1;

    // One-hot grant vector {ch1,ch0} for a channel id.
    function automatic logic [1:0] chan_onehot(input chan_id_t c);
        return (c == CH1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fft_frame_arbiter_rr_pick2.sv
// rr_pick2: combinational two-requester round-robin picker.
//   req_i[1:0] : request vector {ch1,ch0}
//   ptr_i      : preferred channel when both request
//   gnt_o[1:0] : one-hot grant, zero when nothing requests
module rr_pick2
    import fft_ctrl_pkg::*;
(
    input  logic [1:0] req_i,
    input  chan_id_t   ptr_i,
    output logic [1:0] gnt_o
);

    // A lone request wins outright; a tie goes to the pointer.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = chan_onehot(ptr_i);
        end
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: shares one FFT + window-averaging path between two
// sample streams. A grant covers a whole averaging group (NUM_WIN frames
// of FRAME_LEN samples); the next grant waits until the averaged result of
// that group (FRAME_LEN beats) has drained. The drained result is tagged
// with its source channel.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_chN_data/_valid, o_chN_ready requester streams (ch0, ch1)
//   o_fft_data/_valid, i_fft_ready muxed stream to the FFT core (combinational)
//   i_res_valid, i_res_ready       snooped handshake of the averaged result
//   o_res_chan                     channel owning the result being drained
//   o_grant                        one-hot active grant {ch1,ch0}
//   o_busy                         arbiter not idle
//
// Build option FFT_ARB_STATS_EN adds o_ch0_groups / o_ch1_groups: saturating
// 16-bit counts of completed groups per channel.
module fft_frame_arbiter
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = FFT_FRAME_LEN,
    parameter int unsigned NUM_WIN   = FFT_NUM_WIN
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_ch0_data,
    input  logic              i_ch0_data_valid,
    output logic              o_ch0_data_ready,
    input  logic [DATA_W-1:0] i_ch1_data,
    input  logic              i_ch1_data_valid,
    output logic              o_ch1_data_ready,
    output logic [DATA_W-1:0] o_fft_data,
    output logic              o_fft_data_valid,
    input  logic              i_fft_data_ready,
    input  logic              i_res_valid,
    input  logic              i_res_ready,
    output logic              o_res_chan,
    output logic [1:0]        o_grant,
    output logic              o_busy
`ifdef FFT_ARB_STATS_EN
    ,
    output logic [15:0]       o_ch0_groups,
    output logic [15:0]       o_ch1_groups
`endif
);

    localparam int unsigned SAMP_W = $clog2(FRAME_LEN);
    localparam int unsigned WIN_W  = $clog2(NUM_WIN);

    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(FRAME_LEN - 1);
    localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(NUM_WIN - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    chan_id_t          res_chan_q, res_chan_d;
    chan_id_t          rr_ptr_q, rr_ptr_d;
    logic              busy_q, busy_d;
    logic [SAMP_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [SAMP_W-1:0] res_cnt_q, res_cnt_d;

    logic [1:0] pick_gnt;
    logic       in_stream;
    logic       sel_valid;
    logic       accept;
    logic       res_beat;

    rr_pick2 u_pick (
        .req_i (({i_ch1_data_valid, i_ch0_data_valid})),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt)
    );

    // Zero-latency data path; res_chan_q names the granted channel in STREAM.
    assign in_stream        = (state_q == ARB_STREAM);
    assign sel_valid        = (res_chan_q == CH1) ? i_ch1_data_valid : i_ch0_data_valid;
    assign o_fft_data       = (res_chan_q == CH1) ? i_ch1_data : i_ch0_data;
    assign o_fft_data_valid = in_stream & sel_valid;
    assign o_ch0_data_ready = in_stream & (res_chan_q == CH0) & i_fft_data_ready;
    assign o_ch1_data_ready = in_stream & (res_chan_q == CH1) & i_fft_data_ready;

    assign accept   = o_fft_data_valid & i_fft_data_ready;
    assign res_beat = i_res_valid & i_res_ready;

    // Next-state and counter logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        res_chan_d   = res_chan_q;
        rr_ptr_d     = rr_ptr_q;
        sample_cnt_d = sample_cnt_q;
        win_cnt_d    = win_cnt_q;
        res_cnt_d    = res_cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_gnt != 2'b00) begin
                    grant_d    = pick_gnt;
                    res_chan_d = chan_id_t'(pick_gnt[1]);
                    state_d    = ARB_STREAM;
                end
            end
            ARB_STREAM: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + SAMP_ONE;
                    if (sample_cnt_q == SAMP_LAST) begin
                        win_cnt_d = win_cnt_q + WIN_ONE;
                        if (win_cnt_q == WIN_LAST) begin
                            state_d      = ARB_DRAIN;
                            grant_d      = 2'b00;
                            sample_cnt_d = '0;
                            win_cnt_d    = '0;
                        end
                    end
                end
            end
            ARB_DRAIN: begin
                // Only beats seen here belong to this group's result.
                if (res_beat) begin
                    res_cnt_d = res_cnt_q + SAMP_ONE;
                    if (res_cnt_q == SAMP_LAST) begin
                        state_d   = ARB_IDLE;
                        rr_ptr_d  = ~res_chan_q;
                        res_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 2'b00;
            res_chan_q   <= CH0;
            rr_ptr_q     <= CH0;
            busy_q       <= 1'b0;
            sample_cnt_q <= '0;
            win_cnt_q    <= '0;
            res_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            res_chan_q   <= res_chan_d;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            sample_cnt_q <= sample_cnt_d;
            win_cnt_q    <= win_cnt_d;
            res_cnt_q    <= res_cnt_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_busy     = busy_q;
    assign o_res_chan = res_chan_q;

`ifdef FFT_ARB_STATS_EN
    localparam int unsigned    STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] ch0_groups_q, ch0_groups_d;
    logic [STAT_W-1:0] ch1_groups_q, ch1_groups_d;

    // Saturating per-channel group counts, bumped on STREAM -> DRAIN.
    always_comb begin
        ch0_groups_d = ch0_groups_q;
        ch1_groups_d = ch1_groups_q;
        if ((state_q == ARB_STREAM) && (state_d == ARB_DRAIN)) begin
            if (res_chan_q == CH0) begin
                if (ch0_groups_q != STAT_MAX) ch0_groups_d = ch0_groups_q + STAT_ONE;
            end else begin
                if (ch1_groups_q != STAT_MAX) ch1_groups_d = ch1_groups_q + STAT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch0_groups_q <= '0;
            ch1_groups_q <= '0;
        end else begin
            ch0_groups_q <= ch0_groups_d;
            ch1_groups_q <= ch1_groups_d;
        end
    end

    assign o_ch0_groups = ch0_groups_q;
    assign o_ch1_groups = ch1_groups_q;
`endif

endmodule
